// File: rtl/reg_dump_streamer_pkg.sv
// Shared debug-path definitions: dump FSM state encoding and the register
// file geometry constants reused by the UART framer and the register file
// debug port.
package reg_dump_streamer_pkg;

    localparam int REG_ADDR_W = 5;   // register index width (x0..x31)
    localparam int XLEN       = 32;  // architectural register width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Register-dump beat stream.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; once valid is raised, index/data/last stay stable and valid stays
// high until that transfer (or a dump abort/reset drops it).
//   valid  master->slave  beat valid
//   ready  slave->master  sink can accept the beat
//   index  master->slave  register index of the beat
//   data   master->slave  register value of the beat
//   last   master->slave  beat carries the final register
interface reg_dump_streamer_if
    import reg_dump_streamer_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = XLEN
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output index, output data, output last, input ready);
    modport slave  (input valid, input index, input data, input last, output ready);
endinterface

// File: rtl/reg_dump_streamer.sv
// Streams the whole register file out through its debug read port as
// {index, data} beats and keeps a running checksum of the transferred data.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_start      one-cycle dump request (ignored while busy)
//   i_abort      synchronous abort of a running dump
//   o_busy       high from accepted start until return to idle
//   o_done       one-cycle pulse after the last beat is accepted
//   o_dbg_addr   register index to the register file debug port (registered)
//   i_dbg_data   register file debug read data (combinational from o_dbg_addr)
//   o_checksum   wrapping sum of accepted beat data of current/last dump
//   o_state      current FSM state, for observation
//   out_if       beat stream (master side)
module reg_dump_streamer
    import reg_dump_streamer_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDR_W-1:0]    o_dbg_addr,
    input  logic [DATA_W-1:0]    i_dbg_data,
    output logic [DATA_W-1:0]    o_checksum,
    output state_t               o_state,
    reg_dump_streamer_if.master  out_if
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic              r_last;
    logic [ADDR_W-1:0] r_dbg_addr;   // doubles as the scan index
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_checksum;
    logic              w_handshake;

    assign w_handshake = r_valid && out_if.ready;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; abort takes priority over a same-cycle handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_SCAN;
            ST_SCAN: w_state_next = i_abort ? ST_IDLE : ST_SEND;
            ST_SEND: begin
                if (i_abort)          w_state_next = ST_IDLE;
                else if (w_handshake) w_state_next = r_last ? ST_FIN : ST_SCAN;
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: beat register, scan index, checksum, status flags.
    // The debug address only moves after a handshake, so a stalled sink
    // never changes what the register file presents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_dbg_addr <= '0;
            r_index    <= '0;
            r_data     <= '0;
            r_checksum <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_dbg_addr <= '0;
                        r_checksum <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (i_abort) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_data  <= i_dbg_data;
                        r_index <= r_dbg_addr;
                        r_last  <= (r_dbg_addr == LAST_IDX);
                        r_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (i_abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_handshake) begin
                        r_checksum <= r_checksum + r_data;
                        r_valid    <= 1'b0;
                        if (!r_last) begin
                            r_dbg_addr <= r_dbg_addr + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_dbg_addr   = r_dbg_addr;
    assign o_checksum   = r_checksum;
    assign o_state      = r_state;
    assign out_if.valid = r_valid;
    assign out_if.index = r_index;
    assign out_if.data  = r_data;
    assign out_if.last  = r_last;

endmodule

// File: tb/tb_reg_dump_streamer.sv
module tb_reg_dump_streamer;
    import reg_dump_streamer_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_CYC  = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_dbg_addr;
    logic [DATA_W-1:0] i_dbg_data;
    logic [DATA_W-1:0] o_checksum;
    state_t            o_state;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    reg_dump_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    reg_dump_streamer #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_dbg_addr (o_dbg_addr),
        .i_dbg_data (i_dbg_data),
        .o_checksum (o_checksum),
        .o_state    (o_state),
        .out_if     (s_if)
    );

    // clock
    always #5 clk = ~clk;

    // register file debug port model: combinational read
    assign i_dbg_data = regs[o_dbg_addr];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(o_busy), 32'd0);
        check({tag, "_done"},     32'(o_done), 32'd0);
        check({tag, "_valid"},    32'(s_if.valid), 32'd0);
        check({tag, "_last"},     32'(s_if.last), 32'd0);
        check({tag, "_dbg_addr"}, 32'(o_dbg_addr), 32'd0);
        check({tag, "_index"},    32'(s_if.index), 32'd0);
        check({tag, "_data"},     s_if.data, 32'd0);
        check({tag, "_checksum"}, o_checksum, 32'd0);
        check({tag, "_state"},    32'(o_state), 32'(ST_IDLE));
    endtask

    // One dump. Negative beat numbers disable the restart/abort/reset events.
    task automatic run_dump(input int ready_pct, input int restart_beat, input int abort_beat,
                            input int rst_beat, input bit chk_latency, output logic [DATA_W-1:0] sum_out);
        int                beats;
        int                dones;
        int                cyc;
        int                done_cyc;
        logic              prev_stall;
        logic [ADDR_W-1:0] prev_idx;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] exp_sum;

        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(regs[i]);
        exp_sum    = '0;
        beats      = 0;
        dones      = 0;
        done_cyc   = -1;
        prev_stall = 1'b0;
        prev_idx   = '0;
        prev_data  = '0;

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cyc = 0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        check("valid_in_scan", 32'(s_if.valid), 32'd0);
        check("checksum_cleared", o_checksum, 32'd0);

        while (o_busy && cyc < MAX_CYC) begin
            if (s_if.valid) begin
                if (prev_stall) begin
                    check("stall_index_stable", 32'(s_if.index), 32'(prev_idx));
                    check("stall_data_stable", s_if.data, prev_data);
                end
                check("beat_index", 32'(s_if.index), 32'(beats));
                check("beat_data", s_if.data, exp_q[0]);
                check("beat_last", 32'(s_if.last), 32'(beats == NUM_REGS - 1));
            end
            s_if.ready = ($urandom_range(99) < ready_pct);

            if (s_if.valid && beats == restart_beat) i_start = 1'b1;

            if (s_if.valid && beats == abort_beat) begin
                i_abort     = 1'b1;
                s_if.ready  = 1'b1;
                step();
                i_abort = 1'b0;
                check("abort_valid", 32'(s_if.valid), 32'd0);
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_done", 32'(o_done), 32'd0);
                check("abort_checksum_partial", o_checksum, exp_sum);
                check("abort_state", 32'(o_state), 32'(ST_IDLE));
                step();
                check("abort_no_late_done", 32'(o_done), 32'd0);
                sum_out = exp_sum;
                return;
            end

            if (s_if.valid && beats == rst_beat) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("async_rst");
                step();
                step();
                rst = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    step();
                    dones += int'(o_done);
                    check("post_rst_valid", 32'(s_if.valid), 32'd0);
                end
                check("post_rst_no_done", 32'(dones), 32'd0);
                check("post_rst_busy", 32'(o_busy), 32'd0);
                sum_out = exp_sum;
                return;
            end

            prev_stall = s_if.valid && !s_if.ready;
            prev_idx   = s_if.index;
            prev_data  = s_if.data;
            if (s_if.valid && s_if.ready) begin
                exp_sum += exp_q.pop_front();
                beats++;
            end
            step();
            i_start = 1'b0;
            cyc++;
            if (o_done) begin
                dones++;
                done_cyc = cyc;
            end
        end

        check("dump_timeout", 32'(cyc < MAX_CYC), 32'd1);
        check("beat_count", 32'(beats), 32'(NUM_REGS));
        check("done_count", 32'(dones), 32'd1);
        check("done_with_idle", 32'(o_done), 32'd1);
        if (chk_latency) check("done_latency", 32'(done_cyc), 32'd65);
        check("checksum", o_checksum, exp_sum);
        step();
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("idle_after_done", 32'(o_state), 32'(ST_IDLE));
        check("checksum_hold", o_checksum, exp_sum);
        sum_out = exp_sum;
    endtask

    logic [DATA_W-1:0] sum;

    initial begin
        // reset
        rst        = 1'b1;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        s_if.ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'(i) * 32'h0101_0101;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check("idle_no_busy", 32'(o_busy), 32'd0);

        // abort in IDLE has no effect
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("idle_abort_state", 32'(o_state), 32'(ST_IDLE));

        // full dump, sink always ready
        run_dump(100, -1, -1, -1, 1'b1, sum);
        check("checksum_hand_value", o_checksum, 32'hF1F1_F1F0);

        // sink ready about 30% of cycles
        run_dump(30, -1, -1, -1, 1'b0, sum);
        check("checksum_random_ready", o_checksum, 32'hF1F1_F1F0);

        // second start while busy at beat 10 is ignored
        run_dump(100, 10, -1, -1, 1'b1, sum);

        // abort on beat 5 with a same-cycle handshake
        run_dump(100, -1, 5, -1, 1'b0, sum);
        check("abort_partial_hand_value", o_checksum, 32'h0A0A_0A0A);
        run_dump(100, -1, -1, -1, 1'b1, sum);
        check("after_abort_full_checksum", o_checksum, 32'hF1F1_F1F0);

        // checksum wraps
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hFFFF_FFFF;
        run_dump(100, -1, -1, -1, 1'b1, sum);
        check("checksum_wrap", o_checksum, 32'hFFFF_FFE0);

        // asynchronous reset on beat 17
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'(i) * 32'h0101_0101;
        run_dump(100, -1, -1, 17, 1'b0, sum);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
